ps2_rx_param: RTL and testbench
===============================

Name: ps2_rx_param

Overview:
Parametrised PS/2 device-to-host receiver, successor to the fixed 8-bit PS/2 receive block. Samples `ps2c`/`ps2d` and filters the PS/2 clock with a configurable filter depth. Receives 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks start, parity and stop bits. Adds an inter-bit watchdog and a one-entry output holding register with a valid/ready handshake, feeding the keyboard scan-code decoder.

Parameters:
- FILTER_LEN, 8: number of consecutive equal synchronised `ps2c` samples needed to change the filtered clock (range 2..32).
- TIMEOUT_CYCLES, 100000: `clk` cycles allowed between falling edges inside a frame before it is aborted (2 ms at 50 MHz).
- CHECK_PARITY, 1: 1 = odd-parity failure rejects the byte; 0 = parity bit ignored.
- TO_W, $clog2(TIMEOUT_CYCLES): width of the watchdog counter (derived; not to be overridden).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- ps2c, in, 1: raw PS/2 clock line (asynchronous).
- ps2d, in, 1: raw PS/2 data line (asynchronous).
- rx_en, in, 1: permits the start of a new frame.
- dout_ready, in, 1: consumer accepts the held byte.
- dout, out, 8: received data byte.
- dout_valid, out, 1: `dout` holds an unconsumed byte.
- rx_done_tick, out, 1: one-cycle pulse on each good frame.
- parity_err, out, 1: one-cycle pulse on a parity failure.
- frame_err, out, 1: one-cycle pulse on a bad start or stop bit.
- timeout_err, out, 1: one-cycle pulse on a watchdog abort.
- overrun, out, 1: one-cycle pulse when an unconsumed byte is overwritten.
- busy, out, 1: high while state is not IDLE.

Behaviour:
- Reset values:
  - `dout` = 0x00; `dout_valid`, `busy` and all pulse outputs = 0.
  - State = IDLE; bit counter and watchdog = 0.
  - Filter register = all ones; filtered clock = 1.
- Synchronisation and filtering:
  - `ps2c` and `ps2d` each pass through a 2-flop synchroniser.
  - Filter shifts in synchronised `ps2c` every cycle.
  - Filtered clock goes to 1 when the filter is all ones, to 0 when all zeros, otherwise holds.
- `fall_edge` = (filtered clock currently 1) AND (next filtered clock 0). This is a true 1->0 detector; it is combinational and lasts one cycle.
- IDLE:
  - On `fall_edge` & `rx_en` with synchronised `ps2d` = 0: shift it in, bit counter := 9, watchdog := 0, go to DPS.
  - On `fall_edge` & `rx_en` with `ps2d` = 1 (bad start): pulse `frame_err`, stay in IDLE.
  - `fall_edge` while `rx_en` = 0 is ignored.
- DPS:
  - Each `fall_edge` shifts `ps2d` into the 11-bit shift register (MSB side) and clears the watchdog.
  - On a `fall_edge` with counter = 0, go to LOAD; otherwise decrement the counter.
  - With no edge, the watchdog increments. On reaching TIMEOUT_CYCLES-1: pulse `timeout_err`, discard the partial frame, go to IDLE.
  - Deasserting `rx_en` mid-frame does not abort the frame.
- LOAD (exactly 1 cycle, then IDLE):
  - stop_ok = b[10] == 1.
  - par_ok = (XOR of b[9:1]) == 1, or CHECK_PARITY = 0.
  - If not stop_ok: pulse `frame_err`.
  - If not par_ok: pulse `parity_err`. Both error pulses may assert in the same cycle.
  - If both checks pass: pulse `rx_done_tick`, and at the clock edge ending LOAD set `dout` := b[8:1] and `dout_valid` := 1. `dout_valid` therefore rises one cycle after `rx_done_tick`.
  - On any error: `dout`/`dout_valid` are unchanged.
- Output handshake:
  - A byte is consumed on a clock edge where `dout_valid` & `dout_ready` are both high; `dout_valid` then clears.
  - Load and consume on the same edge: the new byte is loaded, `dout_valid` stays 1, no `overrun`.
  - Load while `dout_valid` & ~`dout_ready`: the new byte overwrites `dout` and `overrun` pulses in the LOAD cycle.
- Latency: `rx_done_tick` is asserted 1 cycle after the `fall_edge` of the stop bit. The edge itself lags the line by 2 (sync) + FILTER_LEN cycles.
- Reset mid-frame: everything returns to reset values and the partial frame is lost.
  - If `ps2c` is low at reset release, the filter falls and produces one spurious `fall_edge`.
  - That frame is rejected by the start-bit check or the watchdog. No further handling is required.

Decomposition:
- Shared package `ps2_pkg`:
  - State encoding: IDLE = 2'b00, DPS = 2'b01, LOAD = 2'b10.
  - Constants: PS2_FRAME_BITS = 11, PS2_DATA_BITS = 8, PS2_START = 1'b0, PS2_STOP = 1'b1.
- Sub-module `ps2_clk_filter` (parameter FILTER_LEN):
  - Contains the synchroniser, shift filter, filtered-clock register and `fall_edge` output.
  - Planned for reuse by the PS/2 transmit block.

Test Plan (bench uses TIMEOUT_CYCLES = 200, FILTER_LEN = 4, PS/2 bit period 40 clk):
- Good frame, data 0x1C, parity 0, stop 1, `dout_ready` = 1 -> single `rx_done_tick`; `dout` = 0x1C; `dout_valid` high 1 cycle; no error pulses.
- Frame 0x1C with parity bit 1 -> `parity_err` pulse; `dout_valid` stays 0. Same frame with CHECK_PARITY = 0 -> `dout` = 0x1C accepted.
- Frame 0xF0 (parity 1) with stop bit 0 -> `frame_err` pulse, no byte. Then a good 0xF0 -> `dout` = 0xF0.
- 4 bits of a frame, `ps2c` held high for 250 clk -> `timeout_err` after 200 idle cycles; `busy` falls. Next good frame 0x32 -> `dout` = 0x32.
- `dout_ready` = 0, frames 0x1C then 0x32 -> second LOAD pulses `overrun`; `dout` = 0x32; `dout_valid` = 1. Then `dout_ready` = 1 for 1 cycle -> `dout_valid` = 0.
- 2-cycle low glitch on `ps2c` in IDLE -> no `fall_edge`, `busy` stays 0. Reset asserted after 5 bits -> all outputs at reset values; next frame 0x1C received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM encoding and frame layout constants.
package ps2_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] DPS  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  localparam logic PS2_START = 1'b0;
  localparam logic PS2_STOP  = 1'b1;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, a shift-register
// glitch filter on the clock, and a single-cycle falling-edge strobe.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_edge
);

  logic [1:0]            c_sync_q;
  logic [1:0]            d_sync_q;
  logic [FILTER_LEN-1:0] filter_q;
  logic [FILTER_LEN-1:0] filter_d;
  logic                  f_val_q;
  logic                  f_val_d;

  // Idle PS/2 lines are high, so reset to 1 avoids a false edge out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filter_q <= '1;
      f_val_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the synchroniser really is two stages deep.
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      filter_q <= filter_d;
      f_val_q  <= f_val_d;
    end
  end

  always_comb begin
    filter_d = {c_sync_q[1], filter_q[FILTER_LEN-1:1]};
    if (&filter_q) begin
      f_val_d = 1'b1;
    end else if (~|filter_q) begin
      f_val_d = 1'b0;
    end else begin
      f_val_d = f_val_q;
    end
  end

  assign ps2d_sync = d_sync_q[1];
  assign fall_edge = f_val_q & ~f_val_d;

endmodule

// File: rtl/ps2_rx_param.sv
// PS/2 device-to-host receiver: frames start/8 data/odd parity/stop, flags errors,
// aborts stalled frames, and holds the byte for a valid/ready consumer.
module ps2_rx_param
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit CHECK_PARITY   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic       busy
);

  localparam int             TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic                      ps2d_sync;
  logic                      fall_edge;
  logic [1:0]                state_q, state_d;
  logic [3:0]                n_q, n_d;
  logic [PS2_FRAME_BITS-1:0] b_q, b_d;
  logic [TO_W-1:0]           to_q, to_d;
  logic [PS2_DATA_BITS-1:0]  dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      stop_ok;
  logic                      par_ok;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2d_sync(ps2d_sync),
    .fall_edge(fall_edge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      b_q          <= '0;
      to_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      b_q          <= b_d;
      to_q         <= to_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // b_q[10] is the stop bit, b_q[9] parity, b_q[8:1] data once a frame is in.
  assign stop_ok = (b_q[10] == PS2_STOP);
  assign par_ok  = (^b_q[9:1]) || !CHECK_PARITY;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    n_d          = n_q;
    b_d          = b_q;
    to_d         = to_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rx_done_tick = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    timeout_err  = 1'b0;
    overrun      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_edge && rx_en) begin
          if (ps2d_sync == PS2_START) begin
            b_d     = {ps2d_sync, b_q[PS2_FRAME_BITS-1:1]};
            n_d     = 4'd9;
            to_d    = '0;
            state_d = DPS;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_d  = {ps2d_sync, b_q[PS2_FRAME_BITS-1:1]};
          to_d = '0;
          if (n_q == 4'd0) begin
            state_d = LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (to_q == TO_MAX) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
          n_d         = '0;
          b_d         = '0;
          to_d        = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      LOAD: begin
        state_d      = IDLE;
        frame_err    = !stop_ok;
        parity_err   = !par_ok;
        rx_done_tick = stop_ok && par_ok;
      end
      default: state_d = IDLE;
    endcase

    // A load wins over a same-edge consume, so the new byte stays valid.
    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    if (rx_done_tick) begin
      dout_d       = b_q[8:1];
      dout_valid_d = 1'b1;
      overrun      = dout_valid_q && !dout_ready;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_param.sv
// Scoreboard bench for ps2_rx_param: stimulus pushes expected events from a frame-level
// model, monitors pop and compare whenever the receivers pulse an output.
module tb_ps2_rx_param;

  localparam int FLEN    = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;
  localparam int GAP     = 60;

  typedef struct {
    bit         done;
    bit         perr;
    bit         ferr;
    bit         to;
    bit         ovr;
    logic [7:0] data;
    bit         ready;
    int         t0;
    int         lat_min;
    int         lat_max;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       dout_ready = 1'b1;
  logic [7:0] dout, np_dout;
  logic       dout_valid, rx_done_tick, parity_err, frame_err, timeout_err, overrun, busy;
  logic       np_dout_valid, np_done, np_perr, np_ferr, np_to, np_ovr, np_busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         last_fall = 0;
  exp_t       q[$];
  logic [7:0] q_np[$];
  bit         model_valid = 1'b0;
  logic [7:0] model_dout = 8'h00;

  ps2_rx_param #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TIMEOUT), .CHECK_PARITY(1'b1)) u_dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid),
    .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
  );

  ps2_rx_param #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TIMEOUT), .CHECK_PARITY(1'b0)) u_dut_np (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout_ready(1'b1), .dout(np_dout), .dout_valid(np_dout_valid),
    .rx_done_tick(np_done), .parity_err(np_perr), .frame_err(np_ferr),
    .timeout_err(np_to), .overrun(np_ovr), .busy(np_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    ps2d = b;
    ps2c = 1'b1;
    wait_clk(HALF);
    ps2c = 1'b0;
    last_fall = cyc;
    wait_clk(HALF);
  endtask

  task automatic line_idle(input int n);
    ps2c = 1'b1;
    ps2d = 1'b1;
    rx_en = 1'b1;
    wait_clk(n);
  endtask

  // Frame-level model: the byte is taken only when stop and parity rules hold.
  task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit stop_val,
                            input bit ready, input bit drop_en);
    logic [10:0] bits;
    exp_t        e;
    bit          par_ok, good;
    bits   = {stop_val, (~^data) ^ flip_par, data, 1'b0};
    par_ok = !flip_par;
    good   = par_ok && stop_val;
    dout_ready = ready;
    for (int i = 0; i < 10; i++) begin
      drive_bit(bits[i]);
      if (drop_en && i == 1) rx_en = 1'b0;
    end
    ps2d = bits[10];
    ps2c = 1'b1;
    wait_clk(HALF);
    ps2c = 1'b0;
    e.done = good;
    e.perr = !par_ok;
    e.ferr = !stop_val;
    e.to = 1'b0;
    e.ovr = good && model_valid && !ready;
    e.data = data;
    e.ready = ready;
    e.t0 = cyc;
    e.lat_min = 3 + FLEN;
    e.lat_max = 3 + FLEN;
    q.push_back(e);
    if (stop_val) q_np.push_back(data);
    if (good) model_dout = data;
    model_valid = ready ? 1'b0 : (model_valid | good);
    wait_clk(HALF);
    line_idle(GAP);
  endtask

  task automatic bad_start();
    exp_t e;
    rx_en = 1'b1;
    ps2d = 1'b1;
    ps2c = 1'b1;
    wait_clk(HALF);
    ps2c = 1'b0;
    e = '{done: 1'b0, perr: 1'b0, ferr: 1'b1, to: 1'b0, ovr: 1'b0, data: 8'h00,
          ready: 1'b0, t0: cyc, lat_min: 2 + FLEN, lat_max: 2 + FLEN};
    q.push_back(e);
    wait_clk(HALF);
    line_idle(GAP);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_dout"}, dout, model_dout);
    check({tag, "_dout_valid"}, dout_valid, model_valid);
  endtask

  // Main receiver monitor.
  initial begin
    exp_t       e;
    int         stage = 0;
    bit         pend_ready = 1'b0;
    logic [7:0] pend_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stage = 0;
      end else begin
        if (stage == 1) begin
          check("dout_loaded", dout, pend_data);
          check("dout_valid_set", dout_valid, 1'b1);
          stage = pend_ready ? 2 : 0;
        end else if (stage == 2) begin
          check("dout_valid_consumed", dout_valid, 1'b0);
          stage = 0;
        end
        if (rx_done_tick || parity_err || frame_err || timeout_err || overrun) begin
          check("event_expected", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("rx_done_tick", rx_done_tick, e.done);
            check("parity_err", parity_err, e.perr);
            check("frame_err", frame_err, e.ferr);
            check("timeout_err", timeout_err, e.to);
            check("overrun", overrun, e.ovr);
            check_range("event_latency", cyc - e.t0, e.lat_min, e.lat_max);
            if (rx_done_tick) begin
              stage = 1;
              pend_data = e.data;
              pend_ready = e.ready;
            end
          end
        end
      end
    end
  end

  // Parity-ignoring receiver monitor.
  initial begin
    bit         pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("np_dout", np_dout, pend_data);
          pend = 1'b0;
        end
        if (np_done) begin
          check("np_event_expected", q_np.size() != 0, 1'b1);
          check("np_parity_err", np_perr, 1'b0);
          if (q_np.size() != 0) begin
            pend_data = q_np.pop_front();
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    wait_clk(3);
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {rx_done_tick, parity_err, frame_err, timeout_err, overrun}, 5'b0);
    reset = 1'b1;
    wait_clk(10);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    check_hold("good_1c");
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0);
    check_hold("parity_1c");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_hold("stop0_f0");
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_hold("good_f0");
    bad_start();

    // Partial frame, then silence until the watchdog fires.
    for (int i = 0; i < 4; i++) drive_bit((i == 0) ? 1'b0 : 1'b1);
    ps2c = 1'b1;
    ps2d = 1'b1;
    e = '{done: 1'b0, perr: 1'b0, ferr: 1'b0, to: 1'b1, ovr: 1'b0, data: 8'h00,
          ready: 1'b0, t0: last_fall, lat_min: TIMEOUT, lat_max: TIMEOUT + FLEN + 4};
    q.push_back(e);
    check("busy_in_frame", busy, 1'b1);
    wait_clk(250);
    check("busy_after_timeout", busy, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b1, 1'b0);
    check_hold("good_32");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0, 1'b0);
    check_hold("overrun_32");
    dout_ready = 1'b1;
    wait_clk(1);
    dout_ready = 1'b0;
    model_valid = 1'b0;
    wait_clk(2);
    check_hold("drained");

    ps2c = 1'b0;
    wait_clk(2);
    ps2c = 1'b1;
    wait_clk(30);
    check("busy_after_glitch", busy, 1'b0);

    rx_en = 1'b0;
    drive_bit(1'b0);
    line_idle(5);
    check("busy_rx_en_off", busy, 1'b0);
    rx_en = 1'b0;
    line_idle(GAP);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    check_hold("rx_en_drop");
    for (int i = 0; i < 5; i++) drive_bit((i == 0) ? 1'b0 : 1'b1);
    ps2c = 1'b1;
    ps2d = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    model_valid = 1'b0;
    model_dout = 8'h00;
    check_hold("mid_reset");
    check("mid_reset_busy", busy, 1'b0);
    reset = 1'b1;
    wait_clk(10);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    check_hold("after_reset");

    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = $urandom_range(0, 6);
      if (kind == 6) begin
        bad_start();
      end else begin
        send_frame(8'($urandom), kind == 3 || kind == 5, kind != 4 && kind != 5,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      check_hold("random");
    end

    wait_clk(20);
    check("scoreboard_drained", q.size(), 0);
    check("np_scoreboard_drained", q_np.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
